// File: rtl/btn_enable_pulse.sv
// rtl/btn_enable_pulse.sv - synchronise, debounce and strobe a push-button into one-cycle enables
// Optional auto-repeat while held; all outputs registered.
module btn_enable_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_enable,
    output logic o_btn_level,
    output logic o_busy
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX) + 1;

    // The first stable sample counts as sample 1, so acceptance fires on sample DEBOUNCE_CYCLES.
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] REP_HIT    = HW'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD (mod 2^HW) makes the next hit land exactly PERIOD cycles later.
    localparam logic [HW-1:0] REP_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam bit            REP_EN     = (REPEAT_DELAY > 0);
    localparam bit            DEB_ONE    = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_btn;
    state_t                 state, state_nxt;
    logic [DW-1:0]          deb_cnt, deb_nxt;
    logic [HW-1:0]          hold_cnt, hold_nxt;
    logic                   accept, rep_pulse;
    logic                   enable_nxt, level_nxt, busy_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign s_btn = sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            o_enable    <= 1'b0;
            o_btn_level <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_nxt;
            hold_cnt    <= hold_nxt;
            o_enable    <= enable_nxt;
            o_btn_level <= level_nxt;
            o_busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        accept    = 1'b0;
        rep_pulse = 1'b0;
        case (state)
            IDLE: begin
                deb_nxt  = '0;
                hold_nxt = '0;
                if (s_btn) begin
                    if (DEB_ONE) begin
                        state_nxt = HELD;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = DEB_PRESS;
                        deb_nxt   = DW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (!s_btn) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                    accept    = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!s_btn) begin
                    hold_nxt = '0;
                    if (DEB_ONE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DEB_RELEASE;
                        deb_nxt   = DW'(1);
                    end
                end else if (REP_EN) begin
                    if (hold_cnt == REP_HIT) begin
                        rep_pulse = 1'b1;
                        hold_nxt  = REP_RELOAD;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
            end
            DEB_RELEASE: begin
                if (s_btn) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        enable_nxt = accept | rep_pulse;
        level_nxt  = (state_nxt == HELD) || (state_nxt == DEB_RELEASE);
        busy_nxt   = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_btn_enable_pulse.sv
// tb/tb_btn_enable_pulse.sv - directed bench for btn_enable_pulse (default and auto-repeat builds)
module tb_btn_enable_pulse;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       en_a, lvl_a, busy_a;
    logic       en_b, lvl_b, busy_b;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         pulse_cnt = 0;
    int         pc0;
    logic [3:0] cnt4      = 4'd0;
    logic       en_prev   = 1'b0;

    always #5 clk = ~clk;

    btn_enable_pulse dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn       (btn),
        .o_enable    (en_a),
        .o_btn_level (lvl_a),
        .o_busy      (busy_a)
    );

    btn_enable_pulse #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut_rep (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn       (btn),
        .o_enable    (en_b),
        .o_btn_level (lvl_b),
        .o_busy      (busy_b)
    );

    task automatic chk(input string tag, input logic obs, input logic expd);
        n_checks++;
        assert (obs === expd) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expd);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expd);
        n_checks++;
        assert (obs === expd) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expd);
        end
    endtask

    // Advance one edge, sample 1ns later; also stands in for the downstream 4-bit counter.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("no_double_pulse", en_prev & en_a, 1'b0);
        en_prev = en_a;
        if (en_a) begin
            pulse_cnt++;
            cnt4 = cnt4 + 4'd1;
        end
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) tick();
        chk("rst_enable", en_a, 1'b0);
        chk("rst_level", lvl_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        rst = 1'b0;

        // Clean press: pulse and level at k+5, release falls 5 edges after first 0
        pc0 = pulse_cnt;
        btn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("clean_enable", en_a, c == 5);
            chk("clean_level", lvl_a, c >= 5);
            chk("clean_busy", busy_a, c >= 2);
        end
        btn = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("clean_rel_level", lvl_a, c < 5);
            chk("clean_rel_busy", busy_a, c < 5);
            chk("clean_rel_enable", en_a, 1'b0);
        end
        chk_int("clean_pulses", pulse_cnt - pc0, 1);

        // Glitch of 3 cycles is rejected
        btn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) btn = 1'b0;
            tick();
            chk("glitch_enable", en_a, 1'b0);
            chk("glitch_level", lvl_a, 1'b0);
            chk("glitch_busy", busy_a, (c >= 2) && (c <= 4));
        end

        // Release bounce keeps level high and produces no extra pulse
        pc0 = pulse_cnt;
        btn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("bounce_press_level", lvl_a, c >= 5);
        end
        for (int c = 0; c < 20; c++) begin
            btn = (c >= 2) && (c < 7);
            tick();
            chk("bounce_level", lvl_a, c < 12);
            chk("bounce_enable", en_a, 1'b0);
        end
        chk_int("bounce_pulses", pulse_cnt - pc0, 1);

        // Auto-repeat build: offsets 0, 20, 28, 36, 44 from accept at k+5
        btn = 1'b1;
        for (int c = 0; c < 66; c++) begin
            btn = (c <= 53);
            tick();
            chk("repeat_enable", en_b, (c == 5) || (c == 25) || (c == 33) || (c == 41) || (c == 49));
            chk("repeat_level", lvl_b, (c >= 5) && (c < 59));
        end

        // Reset mid-HELD with button kept pressed
        btn = 1'b1;
        repeat (10) tick();
        chk("pre_reset_level", lvl_a, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_enable", en_a, 1'b0);
        chk("midrst_level", lvl_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        tick();
        chk("midrst_hold_busy", busy_a, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("postrst_enable", en_a, c == 5);
            chk("postrst_level", lvl_a, c >= 5);
        end
        btn = 1'b0;
        repeat (10) tick();

        // Downstream 4-bit count: 3 presses, then 17 total wraps to 1
        cnt4 = 4'd0;
        repeat (3) press();
        chk_int("count_3", int'(cnt4), 3);
        repeat (14) press();
        chk_int("count_wrap", int'(cnt4), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
